// File: rtl/fetch_stage.sv
// Instruction fetch: drives the external PC register through pc_next,
// issues req/ack memory reads and buffers one instruction for decode.
module fetch_stage #(
    parameter int              WIDTH    = 16,
    parameter int              PC_INC   = 1,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic [WIDTH-1:0] pc_next,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             flush,
    input  logic [WIDTH-1:0] flush_target,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_out,
    output logic [WIDTH-1:0] instr_pc
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] addr_q;
    logic             valid_q;
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] ipc_q;

    logic can_issue;
    logic flush_act;
    logic fetch_done;

    assign can_issue  = !valid_q || instr_ready;
    assign flush_act  = flush && (state_q != IDLE);
    assign fetch_done = (state_q == FETCH) && mem_req && mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (flush && mem_req && !mem_ack) state_d = DRAIN;
            DRAIN:   if (mem_ack) state_d = FETCH;
            default: state_d = IDLE;
        endcase
    end

    // Request is withdrawn only while reset is asserted.
    always_comb begin
        mem_req  = 1'b0;
        mem_addr = pc_in;
        unique case (state_q)
            IDLE:    mem_req = 1'b0;
            FETCH:   mem_req = can_issue && !rst;
            DRAIN: begin
                mem_req  = !rst;
                mem_addr = addr_q;
            end
            default: mem_req = 1'b0;
        endcase
    end

    always_comb begin
        pc_next = pc_in;
        if (rst) begin
            pc_next = RESET_PC;
        end else if (flush_act) begin
            pc_next = flush_target;
        end else if (fetch_done) begin
            pc_next = pc_in + WIDTH'(PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            valid_q <= 1'b0;
            out_q   <= '0;
            ipc_q   <= '0;
        end else begin
            if (state_q == FETCH) begin
                addr_q <= pc_in;
            end
            if (flush_act) begin
                valid_q <= 1'b0;
            end else if (fetch_done) begin
                valid_q <= 1'b1;
                out_q   <= mem_rdata;
                ipc_q   <= pc_in;
            end else if (valid_q && instr_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign instr_valid = valid_q;
    assign instr_out   = out_q;
    assign instr_pc    = ipc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with an external PC register and a
// latency-programmable memory model returning addr ^ 0xA5A5.
module tb_fetch_stage;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] pc_q;
    logic [W-1:0] pc_next;
    logic         mem_req;
    logic [W-1:0] mem_addr;
    logic         mem_ack;
    logic [W-1:0] mem_rdata;
    logic         flush;
    logic [W-1:0] flush_target;
    logic         instr_valid;
    logic         instr_ready;
    logic [W-1:0] instr_out;
    logic [W-1:0] instr_pc;

    int lat;
    int wait_cnt;
    int n_chk;
    int n_err;

    always #5 clk = ~clk;

    fetch_stage #(.WIDTH(W), .PC_INC(1), .RESET_PC(16'h0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_in        (pc_q),
        .pc_next      (pc_next),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .flush        (flush),
        .flush_target (flush_target),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_out    (instr_out),
        .instr_pc     (instr_pc)
    );

    always_ff @(posedge clk) pc_q <= pc_next;

    always_comb begin
        mem_ack   = mem_req && (wait_cnt >= lat);
        mem_rdata = mem_addr ^ 16'hA5A5;
    end

    initial wait_cnt = 0;
    always_ff @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                     wait_cnt <= 0;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        lat = 0;
        rst = 1'b1;
        flush = 1'b0;
        flush_target = '0;
        instr_ready = 1'b1;

        // reset
        nxt(); #1;
        check("rst_pc_next", 32'(pc_next), 32'h0);
        check("rst_req", 32'(mem_req), 32'h0);
        nxt(); #1;
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_out", 32'(instr_out), 32'h0);
        check("rst_ipc", 32'(instr_pc), 32'h0);
        check("rst_pc", 32'(pc_q), 32'h0);
        rst = 1'b0;
        #1;
        check("idle_req", 32'(mem_req), 32'h0);
        check("idle_pc_next", 32'(pc_next), 32'h0);
        nxt(); #1;
        check("f0_req", 32'(mem_req), 32'h1);
        check("f0_addr", 32'(mem_addr), 32'h0);
        check("f0_pc_next", 32'(pc_next), 32'h1);

        // zero-wait streaming
        begin
            logic [15:0] exp_out [4];
            exp_out[0] = 16'hA5A5;
            exp_out[1] = 16'hA5A4;
            exp_out[2] = 16'hA5A7;
            exp_out[3] = 16'hA5A6;
            for (int i = 0; i < 4; i++) begin
                nxt(); #1;
                check("str_valid", 32'(instr_valid), 32'h1);
                check("str_ipc", 32'(instr_pc), 32'(i));
                check("str_out", 32'(instr_out), 32'(exp_out[i]));
            end
        end

        // 3-cycle latency at PC=5
        instr_ready = 1'b0;
        flush = 1'b1;
        flush_target = 16'h0005;
        lat = 2;
        #1;
        check("bp_req_off", 32'(mem_req), 32'h0);
        nxt();
        flush = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) nxt();
            #1;
            check("lat_req", 32'(mem_req), 32'h1);
            check("lat_addr", 32'(mem_addr), 32'h5);
            check("lat_ack", 32'(mem_ack), (i == 2) ? 32'h1 : 32'h0);
            if (i < 2) check("lat_pc_next", 32'(pc_next), 32'h5);
        end
        nxt(); #1;
        check("lat_pc", 32'(pc_q), 32'h6);
        check("lat_valid", 32'(instr_valid), 32'h1);
        check("lat_ipc", 32'(instr_pc), 32'h5);
        check("lat_out", 32'(instr_out), 32'hA5A0);

        // backpressure after instruction at PC=0
        lat = 0;
        rst = 1'b1;
        nxt();
        rst = 1'b0;
        nxt();
        nxt();
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_valid", 32'(instr_valid), 32'h1);
            check("bp_ipc", 32'(instr_pc), 32'h0);
            check("bp_out", 32'(instr_out), 32'hA5A5);
            check("bp_req", 32'(mem_req), 32'h0);
            check("bp_pc", 32'(pc_q), 32'h1);
            nxt();
        end
        instr_ready = 1'b1;
        #1;
        check("bp_rereq", 32'(mem_req), 32'h1);
        check("bp_readdr", 32'(mem_addr), 32'h1);
        nxt(); #1;
        check("bp_next_ipc", 32'(instr_pc), 32'h1);
        check("bp_next_out", 32'(instr_out), 32'hA5A4);

        // flush while request to 0x0010 is pending
        instr_ready = 1'b0;
        flush = 1'b1;
        flush_target = 16'h0010;
        lat = 1000;
        nxt();
        flush = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("dr_req", 32'(mem_req), 32'h1);
        check("dr_addr0", 32'(mem_addr), 32'h10);
        nxt();
        flush = 1'b1;
        flush_target = 16'h0040;
        #1;
        check("dr_pc_next", 32'(pc_next), 32'h40);
        nxt();
        flush = 1'b0;
        #1;
        check("dr_hold_req", 32'(mem_req), 32'h1);
        check("dr_hold_addr", 32'(mem_addr), 32'h10);
        check("dr_valid", 32'(instr_valid), 32'h0);
        check("dr_pc", 32'(pc_q), 32'h40);
        check("dr_pc_next2", 32'(pc_next), 32'h40);
        nxt();
        lat = 0;
        #1;
        check("dr_ack_addr", 32'(mem_addr), 32'h10);
        check("dr_ack", 32'(mem_ack), 32'h1);
        nxt(); #1;
        check("dr_discard", 32'(instr_valid), 32'h0);
        check("dr_new_req", 32'(mem_req), 32'h1);
        check("dr_new_addr", 32'(mem_addr), 32'h40);
        nxt(); #1;
        check("dr_new_ipc", 32'(instr_pc), 32'h40);
        check("dr_new_out", 32'(instr_out), 32'hA5E5);

        // flush coincident with ack for 0x0020
        instr_ready = 1'b0;
        flush = 1'b1;
        flush_target = 16'h0020;
        nxt();
        instr_ready = 1'b1;
        flush_target = 16'h0100;
        #1;
        check("fa_req", 32'(mem_req), 32'h1);
        check("fa_ack", 32'(mem_ack), 32'h1);
        check("fa_addr", 32'(mem_addr), 32'h20);
        check("fa_pc_next", 32'(pc_next), 32'h100);
        nxt();
        flush = 1'b0;
        #1;
        check("fa_valid", 32'(instr_valid), 32'h0);
        check("fa_addr2", 32'(mem_addr), 32'h100);
        nxt(); #1;
        check("fa_valid2", 32'(instr_valid), 32'h1);
        check("fa_ipc", 32'(instr_pc), 32'h100);
        check("fa_out", 32'(instr_out), 32'hA4A5);

        // wrap-around at 0xFFFF
        instr_ready = 1'b0;
        flush = 1'b1;
        flush_target = 16'hFFFF;
        nxt();
        flush = 1'b0;
        instr_ready = 1'b1;
        #1;
        check("wr_addr", 32'(mem_addr), 32'hFFFF);
        check("wr_pc_next", 32'(pc_next), 32'h0);
        nxt(); #1;
        check("wr_ipc0", 32'(instr_pc), 32'hFFFF);
        check("wr_out0", 32'(instr_out), 32'h5A5A);
        nxt(); #1;
        check("wr_ipc1", 32'(instr_pc), 32'h0);
        check("wr_out1", 32'(instr_out), 32'hA5A5);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage wrapped around the 16-bit program counter register. It consumes the PC value and produces the PC's next input.
- The PC register has no reset and no enable, so this block holds, advances or redirects the PC through pc_next.
- It issues req/ack reads to instruction memory and presents each fetched instruction, tagged with its PC, to decode through a one-entry valid/ready buffer.

Parameters:
WIDTH, 16, PC / address / instruction width
PC_INC, 1, PC increment per fetched instruction
RESET_PC, 0, PC value driven onto pc_next while rst is high

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
pc_in  input  WIDTH  current PC (program counter out)
pc_next  output  WIDTH  next PC (program counter in); combinational
mem_req  output  1  instruction read request
mem_addr  output  WIDTH  read address
mem_ack  input  1  read complete; mem_rdata valid this cycle
mem_rdata  input  WIDTH  instruction word
flush  input  1  redirect request (branch/jump taken)
flush_target  input  WIDTH  redirect PC
instr_valid  output  1  instr_out/instr_pc valid
instr_ready  input  1  decode accepts this cycle
instr_out  output  WIDTH  fetched instruction
instr_pc  output  WIDTH  PC of instr_out

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset:
  - State goes to IDLE; instr_valid=0, instr_out=0, instr_pc=0, addr_q=0; mem_req=0.
  - While rst=1, pc_next=RESET_PC, so the PC loads RESET_PC on every reset edge.
  - Reset mid-request drops the request. Memory must tolerate req withdrawal on reset only.
- States:
  - IDLE: mem_req=0, pc_next=pc_in. Always goes to FETCH next cycle.
  - FETCH: can_issue = !instr_valid || instr_ready. mem_req=can_issue, mem_addr=pc_in. addr_q<=pc_in every cycle.
  - DRAIN: mem_req=1, mem_addr=addr_q, pc_next=pc_in. Any mem_rdata returned here is discarded.
- Request stability: once mem_req rises, req and addr stay stable until mem_ack. Same-cycle ack (req and ack in one cycle) is legal.
- Fetch completion (FETCH, mem_req && mem_ack, no flush):
  - instr_out<=mem_rdata, instr_pc<=pc_in, instr_valid<=1.
  - pc_next=pc_in+PC_INC, so the PC advances on the same edge.
  - This overwrites the buffer when instr_valid && instr_ready.
- Throughput: 1 instruction/cycle with zero-wait memory. Fetch-to-instr_valid latency is 1 clock after ack.
- Buffer drain: instr_valid && instr_ready with no new ack gives instr_valid<=0.
- Hold: in every other non-flush case, pc_next=pc_in. instr_valid && !instr_ready holds instr_out/instr_pc unchanged.
- Flush (highest priority after rst, any state except IDLE):
  - pc_next=flush_target and instr_valid<=0; the buffered instruction is dropped.
  - FETCH with mem_req && !mem_ack goes to DRAIN. addr_q holds the in-flight address, not the new PC.
  - FETCH with mem_req && mem_ack: data discarded, PC not incremented, stays in FETCH.
  - FETCH with mem_req=0 stays in FETCH.
  - Flush in DRAIN updates pc_next=flush_target and stays in DRAIN.
- DRAIN exit: on mem_ack, go to FETCH. The next request uses the redirected pc_in.
- Arithmetic: pc_in+PC_INC is truncated to WIDTH. 0xFFFF+1 = 0x0000, and wrap is not an error.
- No instruction is ever duplicated or skipped except by flush.

Test Plan:
- Reset, zero-wait memory returning mem_rdata=addr^0xA5A5, instr_ready=1:
  - rst high 2 cycles then low -> PC=0.
  - instr_pc sequence 0,1,2,3 on consecutive cycles with instr_out=0xA5A5,0xA5A4,0xA5A7,0xA5A6.
- Memory with 3-cycle ack latency at PC=5:
  - mem_req high 3 cycles with mem_addr=5, pc_next=5 throughout.
  - After ack: PC=6, instr_valid=1, instr_pc=5.
- Backpressure with instr_ready=0 for 4 cycles after the first instruction (PC=0):
  - instr_valid stays 1, instr_out/instr_pc stable, mem_req=0, PC holds 1.
  - On instr_ready=1, the same-cycle re-request resumes.
- flush_target=0x0040 while a request to 0x0010 is pending without ack:
  - Enter DRAIN, mem_addr stays 0x0010, PC becomes 0x0040, instr_valid=0.
  - The returned word is discarded; the next request has mem_addr=0x0040.
- flush_target=0x0100 in the same cycle as an ack for 0x0020 -> that data is never presented; next instr_pc=0x0100.
- Wrap-around with PC=0xFFFF and zero-wait memory -> instr_pc=0xFFFF followed by instr_pc=0x0000.
